// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element of the serial sequencer.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell walks the operands LSB first,
// with the carry held in a flop between cycles.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = (cnt == CNT_W'(WIDTH - 1));
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start seen in DONE begins the next operation with no idle gap.
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                // Subtraction is a + ~b + 1: invert B up front and force the carry.
                a_sr  <= a;
                b_sr  <= b ^ {WIDTH{sub}};
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                sum   <= {bit_s, sum[WIDTH-1:1]};
                a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                carry <= bit_c;
                cnt   <= cnt + 1'b1;
                if (last_bit) begin
                    cout <= bit_c;
                    ovf  <= carry ^ bit_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        int          u;
        int          s;
        logic [W-1:0] r;
        logic        co;
        logic        ov;
        if (!sb) begin
            u  = int'(x) + int'(y) + int'(ci);
            s  = int'($signed(x)) + int'($signed(y)) + int'(ci);
            co = (u > 255);
        end else begin
            u  = int'(x) - int'(y);
            s  = int'($signed(x)) - int'($signed(y));
            co = (x >= y);
        end
        r  = W'(u);
        ov = (s > 127) || (s < -128);
        return {ov, co, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] exp);
        check({tag, "_sum"},  32'(sum),  32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        check({tag, "_ovf"},  32'(ovf),  32'(exp[W+1]));
    endtask

    // Runs one operation from an idle state. A nonzero poke_cycle pulses start
    // with other operands during that SHIFT cycle. Checks latency, busy length,
    // result and that no second done follows.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input int poke_cycle);
        logic [W+1:0] exp;
        int           cycles;
        int           busy_cnt;
        int           extra_done;
        exp      = model(x, y, ci, sb);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        start    = 1'b1;
        cycles   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            cycles++;
            start = (poke_cycle != 0) && (cycles == poke_cycle);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            if (busy) busy_cnt++;
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'(W + 1));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(W));
        check_result(tag, exp);
        extra_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check({tag, "_one_done"}, 32'(extra_done), 32'd0);
        check({tag, "_held_sum"}, 32'(sum), 32'(exp[W-1:0]));
    endtask

    initial begin
        logic [W+1:0] exp1;
        logic [W+1:0] exp2;
        int           gap;
        int           dones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst", '0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed operand cases including signed overflow, wrap and borrow.
        run_op("add_ovf", 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        check("add_ovf_const", 32'({ovf, cout, sum}), 32'h296);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op("add_wrap_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 0);
        run_op("sub_borrow", 8'h10, 8'h20, 1'b0, 1'b1, 0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 0);
        check("sub_ovf_const", 32'({ovf, cout, sum}), 32'h37F);
        run_op("sub_cin_ignored", 8'h33, 8'h11, 1'b1, 1'b1, 0);

        // Start pulsed during SHIFT is ignored.
        run_op("start_busy", 8'h12, 8'h34, 1'b0, 1'b0, 3);

        // Back-to-back: start held through DONE.
        exp1  = model(8'h7F, 8'h01, 1'b0, 1'b0);
        exp2  = model(8'h01, 8'h02, 1'b0, 1'b1);
        a     = 8'h7F;
        b     = 8'h01;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        gap   = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("b2b_first_done", 32'(done), 32'd1);
        check_result("b2b_first", exp1);
        a   = 8'h01;
        b   = 8'h02;
        sub = 1'b1;
        @(negedge clk);
        check("b2b_no_idle", 32'(busy), 32'd1);
        start = 1'b0;
        gap   = 1;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) break;
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'(W + 1));
        check_result("b2b_second", exp2);
        repeat (2) @(negedge clk);

        // Reset in the 4th SHIFT cycle discards the operation.
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check_result("mid_rst", '0);
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("mid_rst_quiet", 32'(dones), 32'd0);

        // Reset and start together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_wins", 32'(busy), 32'd0);

        run_op("after_rst", 8'hC8, 8'h64, 1'b0, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), 1'($urandom), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
